project_switch_sequencer: RTL
=============================

// Module: project_switch_sequencer
// PURPOSE
//  Wishbone-controlled sequencer that owns project selection for the multi-project harness.
//  Switches safely: tristates all pads, swaps active_project, holds the new project in reset, then releases.
//  Optional auto-rotation cycles through a project mask for demo use.
//  Drives the harness io_out/io_in mux select, io_oeb and per-project reset.
// PARAMETERS
//  BASE_ADDR     32'h30000000  register window base; 8 words, BASE..BASE+0x1C
//  NUM_PROJECTS  6             valid project indices 0..NUM_PROJECTS-1
//  IO_PADS       38            pad count (MPRJ_IO_PADS)
//  GUARD_CYCLES  16            DRAIN length, pads forced to input (>=1)
//  RESET_CYCLES  8             SETTLE length, proj_reset_o high (>=1)
// PORTS
//  wb_clk_i          in   1        clock (single clock domain)
//  wb_rst_i          in   1        reset, asynchronous, active-high
//  wbs_stb_i/cyc_i   in   1/1      wishbone strobe / cycle; valid = cyc & stb
//  wbs_we_i          in   1        write enable
//  wbs_sel_i         in   4        byte selects
//  wbs_adr_i         in   32       address
//  wbs_dat_i         in   32       write data
//  wbs_ack_o         out  1        ack, registered
//  wbs_dat_o         out  32       read data, registered
//  active_project_o  out  8        mux select to harness
//  oeb_o             out  IO_PADS  pad output-enable-bar (1 = input)
//  proj_reset_o      out  1        reset to newly selected project
//  busy_o            out  1        high in DRAIN/SWITCH/SETTLE
// BEHAVIOUR
//  Reset values: active_project_o=0, oeb_o=all 1, proj_reset_o=1, busy_o=1, ack=0, dat_o=0, state=SETTLE, err=0.
//  Registers: +0 SELECT (wr byte0 = request; rd {err,..,busy,state[1:0],active[7:0]}),
//   +4 OEB_LO[31:0], +8 OEB_HI[IO_PADS-33:0] (full-word writes only, sel!=4'hF ignored),
//   +C DWELL[31:0], +10 ROTMASK[NUM_PROJECTS-1:0]; other window words read 0, writes ignored.
//  Wishbone: ack one cycle after valid inside window, one-cycle pulse, then low while valid stays high
//   (no back-to-back ack for same transfer); addresses outside window never acked; dat_o=0 when not acking.
//  FSM: RUN -> DRAIN (GUARD_CYCLES) -> SWITCH (1 cycle) -> SETTLE (RESET_CYCLES) -> RUN.
//   DRAIN: oeb_o all 1, active unchanged. SWITCH: active_project_o <= pending; oeb_o all 1.
//   SETTLE: proj_reset_o=1, oeb_o=OEB image. RUN: proj_reset_o=0, oeb_o tracks OEB image next cycle.
//  Latency: SELECT write accepted at edge T -> DRAIN from T+1; active changes at edge T+1+GUARD_CYCLES;
//   proj_reset_o falls GUARD_CYCLES+1+RESET_CYCLES cycles after DRAIN entry.
//  Request == active while RUN: no sequence, ack only. Request >= NUM_PROJECTS: ignored, err=1 (sticky
//   until next valid request or reset).
//  Request while busy: stored as pending (last write wins), serviced on RUN entry with a full new sequence.
//  Reset mid-sequence: async return to reset values; sequence restarts in SETTLE for project 0.
//  Counters saturate-free: load at state entry, decrement to 0, leave state on 0.
// CONFIGURATION
//  SEQ_AUTO_ROTATE_EN defined: in RUN with DWELL!=0 a dwell counter counts RUN cycles; at DWELL it
//   requests next set bit of ROTMASK above active, wrapping to bit 0; mask empty or only active set:
//   no switch, counter restarts. Any manual SELECT write restarts the counter. DWELL write restarts it.
//  Not defined: DWELL/ROTMASK read 0, writes acked and ignored; selection is manual only.
// TESTING
//  Reset release -> proj_reset_o high 8 cycles, active=0, oeb_o=all 1, busy_o falls with proj_reset_o.
//  Write SELECT=3 at T -> oeb_o all 1 from T+1, active=3 at T+17, proj_reset_o low at T+25, ack at T+1 only.
//  Write SELECT=9 -> active unchanged, no DRAIN, STATUS read bit31=1; then SELECT=2 clears err.
//  During DRAIN write SELECT=4 then SELECT=5 -> after current switch, second sequence ends active=5.
//  OEB_LO=0xFFFF00FF in RUN -> oeb_o[31:0] updates next cycle; sel=4'h3 write leaves it unchanged.
//  SEQ_AUTO_ROTATE_EN: ROTMASK=6'b100101, DWELL=100, active=0 -> visits 2,5,0 each after 100 RUN cycles.

Source files
------------

// File: rtl/project_switch_sequencer.sv
// Wishbone-controlled project selection sequencer: drain pads, swap mux select, hold new project in reset.
// Optional auto-rotation through a project mask when SEQ_AUTO_ROTATE_EN is defined.
module project_switch_sequencer #(
  parameter logic [31:0] BASE_ADDR    = 32'h3000_0000,
  parameter int          NUM_PROJECTS = 6,
  parameter int          IO_PADS      = 38,
  parameter int          GUARD_CYCLES = 16,
  parameter int          RESET_CYCLES = 8
) (
  input  logic               wb_clk_i,
  input  logic               wb_rst_i,
  input  logic               wbs_stb_i,
  input  logic               wbs_cyc_i,
  input  logic               wbs_we_i,
  input  logic [3:0]         wbs_sel_i,
  input  logic [31:0]        wbs_adr_i,
  input  logic [31:0]        wbs_dat_i,
  output logic               wbs_ack_o,
  output logic [31:0]        wbs_dat_o,
  output logic [7:0]         active_project_o,
  output logic [IO_PADS-1:0] oeb_o,
  output logic               proj_reset_o,
  output logic               busy_o
);
  typedef enum logic [1:0] {RUN = 2'd0, DRAIN = 2'd1, SWITCH = 2'd2, SETTLE = 2'd3} state_e;

  typedef struct packed {
    logic       vld;
    logic       we;
    logic       full;
    logic [2:0] word;
  } wb_req_t;

  state_e             state_q, state_d;
  logic [15:0]        cnt_q, cnt_d;
  logic [7:0]         active_q, active_d, target_q, target_d, pend_q, pend_d;
  logic               pend_vld_q, pend_vld_d, err_q, err_d, ack_q, ack_d;
  logic [31:0]        dat_q, dat_d, rdata;
  logic [IO_PADS-1:0] oeb_img_q, oeb_img_d;
  wb_req_t            req;
  logic               acc, wr, sel_wr, sel_bad, start, rot_req;
  logic [7:0]         start_tgt, rot_next;

  assign req.vld  = wbs_cyc_i & wbs_stb_i & (wbs_adr_i[31:5] == BASE_ADDR[31:5]);
  assign req.we   = wbs_we_i;
  assign req.full = (wbs_sel_i == 4'hF);
  assign req.word = wbs_adr_i[4:2];

  // One ack per transfer: a held strobe is not re-accepted on the cycle after ack.
  assign acc     = req.vld & ~ack_q;
  assign wr      = acc & req.we;
  assign sel_wr  = wr & (req.word == 3'd0) & wbs_sel_i[0];
  assign sel_bad = ({24'd0, wbs_dat_i[7:0]} >= 32'(NUM_PROJECTS));

  logic unused_adr;
  assign unused_adr = ^wbs_adr_i[1:0];

`ifdef SEQ_AUTO_ROTATE_EN
  logic [31:0]               dwell_q, dwell_d, dwell_cnt_q, dwell_cnt_d;
  logic [NUM_PROJECTS-1:0]   rotmask_q, rotmask_d;
  logic [2*NUM_PROJECTS-1:0] rot_dbl;
  logic [7:0]                rot_off, rot_sum;
  logic                      rot_hit, dwell_wr, dwell_end;

  // Doubled mask shifted past the active bit: lowest set bit is the next project, wrapping.
  always_comb begin
    rot_dbl = {rotmask_q, rotmask_q} >> (active_q + 8'd1);
    rot_hit = 1'b0;
    rot_off = 8'd0;
    for (int i = NUM_PROJECTS-2; i >= 0; i--) begin
      if (rot_dbl[i]) begin
        rot_hit = 1'b1;
        rot_off = 8'(i);
      end
    end
    rot_sum  = active_q + 8'd1 + rot_off;
    rot_next = (rot_sum >= 8'(NUM_PROJECTS)) ? rot_sum - 8'(NUM_PROJECTS) : rot_sum;
  end

  assign dwell_wr  = wr & (req.word == 3'd3);
  assign dwell_end = (state_q == RUN) && (dwell_q != 32'd0) && (dwell_cnt_q + 32'd1 == dwell_q);
  assign rot_req   = dwell_end & rot_hit;

  always_comb begin
    dwell_d     = dwell_wr ? wbs_dat_i : dwell_q;
    rotmask_d   = (wr && req.word == 3'd4) ? wbs_dat_i[NUM_PROJECTS-1:0] : rotmask_q;
    dwell_cnt_d = dwell_cnt_q + 32'd1;
    if (state_q != RUN || sel_wr || dwell_wr || dwell_end || dwell_q == 32'd0)
      dwell_cnt_d = 32'd0;
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      dwell_q     <= 32'd0;
      rotmask_q   <= '0;
      dwell_cnt_q <= 32'd0;
    end else begin
      dwell_q     <= dwell_d;
      rotmask_q   <= rotmask_d;
      dwell_cnt_q <= dwell_cnt_d;
    end
  end
`else
  assign rot_req  = 1'b0;
  assign rot_next = 8'd0;
`endif

  always_comb begin
    rdata = 32'd0;
    case (req.word)
      3'd0: rdata = {err_q, 20'd0, busy_o, state_q, active_q};
      3'd1: rdata = oeb_img_q[31:0];
      3'd2: rdata = {{(64-IO_PADS){1'b0}}, oeb_img_q[IO_PADS-1:32]};
`ifdef SEQ_AUTO_ROTATE_EN
      3'd3: rdata = dwell_q;
      3'd4: rdata = {{(32-NUM_PROJECTS){1'b0}}, rotmask_q};
`endif
      default: rdata = 32'd0;
    endcase
  end

  always_comb begin
    ack_d      = acc;
    dat_d      = (acc && !req.we) ? rdata : 32'd0;
    state_d    = state_q;
    cnt_d      = cnt_q;
    active_d   = active_q;
    target_d   = target_q;
    pend_d     = pend_q;
    pend_vld_d = pend_vld_q;
    err_d      = err_q;
    oeb_img_d  = oeb_img_q;
    start      = 1'b0;
    start_tgt  = target_q;

    if (wr && req.full && req.word == 3'd1) oeb_img_d[31:0] = wbs_dat_i;
    if (wr && req.full && req.word == 3'd2) oeb_img_d[IO_PADS-1:32] = wbs_dat_i[IO_PADS-33:0];

    // A fresh write beats a queued request, which beats rotation.
    if (sel_wr) begin
      if (sel_bad) begin
        err_d = 1'b1;
      end else begin
        err_d = 1'b0;
        if (state_q == RUN) begin
          pend_vld_d = 1'b0;
          if (wbs_dat_i[7:0] != active_q) begin
            start     = 1'b1;
            start_tgt = wbs_dat_i[7:0];
          end
        end else begin
          pend_d     = wbs_dat_i[7:0];
          pend_vld_d = 1'b1;
        end
      end
    end else if (state_q == RUN && pend_vld_q) begin
      pend_vld_d = 1'b0;
      if (pend_q != active_q) begin
        start     = 1'b1;
        start_tgt = pend_q;
      end
    end else if (rot_req) begin
      start     = 1'b1;
      start_tgt = rot_next;
    end

    case (state_q)
      RUN: if (start) begin
        state_d  = DRAIN;
        cnt_d    = 16'(GUARD_CYCLES - 1);
        target_d = start_tgt;
      end
      DRAIN: if (cnt_q == 16'd0) state_d = SWITCH;
             else cnt_d = cnt_q - 16'd1;
      SWITCH: begin
        state_d  = SETTLE;
        active_d = target_q;
        cnt_d    = 16'(RESET_CYCLES - 1);
      end
      SETTLE: if (cnt_q == 16'd0) state_d = RUN;
              else cnt_d = cnt_q - 16'd1;
      default: state_d = SETTLE;
    endcase
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q    <= SETTLE;
      cnt_q      <= 16'(RESET_CYCLES - 1);
      active_q   <= 8'd0;
      target_q   <= 8'd0;
      pend_q     <= 8'd0;
      pend_vld_q <= 1'b0;
      err_q      <= 1'b0;
      ack_q      <= 1'b0;
      dat_q      <= 32'd0;
      oeb_img_q  <= '1;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      active_q   <= active_d;
      target_q   <= target_d;
      pend_q     <= pend_d;
      pend_vld_q <= pend_vld_d;
      err_q      <= err_d;
      ack_q      <= ack_d;
      dat_q      <= dat_d;
      oeb_img_q  <= oeb_img_d;
    end
  end

  assign wbs_ack_o        = ack_q;
  assign wbs_dat_o        = dat_q;
  assign active_project_o = active_q;
  assign oeb_o            = (state_q == DRAIN || state_q == SWITCH) ? '1 : oeb_img_q;
  assign proj_reset_o     = (state_q == SETTLE);
  assign busy_o           = (state_q != RUN);
endmodule
